// File: rtl/test_runner_pkg.sv
// Shared types and defaults for the fixture sequencer and its watchdog.
package test_runner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/test_runner_if.sv
// Control/status bundle between the test runner and the fixture array it sequences.
interface test_runner_if #(
  parameter int unsigned N_TESTS = 4
);
  logic               i_start;
  logic [N_TESTS-1:0] o_run;
  logic [N_TESTS-1:0] i_running;
  logic [N_TESTS-1:0] i_passed;
  logic               o_busy;
  logic               o_done;
  logic               o_passed;
  logic [N_TESTS-1:0] o_fail_vec;
  logic               o_timeout;

  modport slave (
    input  i_start, i_running, i_passed,
    output o_run, o_busy, o_done, o_passed, o_fail_vec, o_timeout
  );

  modport master (
    output i_start, i_running, i_passed,
    input  o_run, o_busy, o_done, o_passed, o_fail_vec, o_timeout
  );
endinterface

// File: rtl/test_runner_watchdog.sv
// Per-fixture cycle counter; expires on the cycle the count reaches TIMEOUT-1, saturates at TIMEOUT.
module run_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)
      cnt_d = '0;
    else if (i_enable && (cnt_q != SAT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == LAST);
endmodule

// File: rtl/test_runner.sv
// Sequences N one-shot test fixtures, bounds each with a watchdog and aggregates a board verdict.
module test_runner
  import test_runner_pkg::*;
#(
  parameter int unsigned N_TESTS      = 4,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  test_runner_if.slave  bus
);
  localparam int unsigned   IW       = idx_width(N_TESTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_TESTS - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_TESTS-1:0]   fail_q, fail_d;
  logic                 to_q, to_d;
  logic                 passed_q, passed_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wd_clear, wd_enable, wd_expired;
  logic                 sel_running, sel_passed;
  logic [N_TESTS-1:0]   run;

  assign sel_running = bus.i_running[idx_q];
  assign sel_passed  = bus.i_passed[idx_q];

  run_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (wd_clear),
    .i_enable  (wd_enable),
    .o_expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    to_d      = to_q;
    passed_d  = passed_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d  = ST_LAUNCH;
          idx_d    = '0;
          fail_d   = '0;
          to_d     = 1'b0;
          passed_d = 1'b0;
        end
      end
      ST_LAUNCH: begin
        wd_clear = 1'b1;
        // A fixture not running on its first launch cycle is stale from an earlier run.
        if (!sel_running) begin
          fail_d[idx_q] = 1'b1;
          state_d       = ST_NEXT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_enable = 1'b1;
        if (!sel_running) begin
          fail_d[idx_q] = ~sel_passed;
          state_d       = ST_NEXT;
        end else if (wd_expired) begin
          fail_d[idx_q] = 1'b1;
          to_d          = 1'b1;
          state_d       = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if ((idx_q == LAST_IDX) || (STOP_ON_FAIL && fail_q[idx_q])) begin
          state_d  = ST_DONE;
          passed_d = (fail_q == '0) && (idx_q == LAST_IDX);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) || (state_d == ST_NEXT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      fail_q   <= '0;
      to_q     <= 1'b0;
      passed_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      to_q     <= to_d;
      passed_q <= passed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    run = '0;
    if ((state_q == ST_LAUNCH) || (state_q == ST_WAIT))
      run[idx_q] = 1'b1;
  end

  assign bus.o_run      = run;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_passed   = passed_q;
  assign bus.o_fail_vec = fail_q;
  assign bus.o_timeout  = to_q;
endmodule

// File: tb/tb_test_runner.sv
// Two runners (halt-on-fail and run-all) driven by behavioural fixtures and checked per cycle against a timeline model.
module tb_test_runner;
  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 16;
  localparam int          TL  = 128;
  localparam int          BIG = 32'h7fffffff;

  typedef struct packed {
    logic [N-1:0] run;
    logic         busy;
    logic         done;
    logic         passed;
    logic [N-1:0] fail;
    logic         to;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  test_runner_if #(.N_TESTS(N)) bus0 ();
  test_runner_if #(.N_TESTS(N)) bus1 ();

  test_runner #(.N_TESTS(N), .TIMEOUT(TO), .STOP_ON_FAIL(1'b1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
  test_runner #(.N_TESTS(N), .TIMEOUT(TO), .STOP_ON_FAIL(1'b0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

  // Fixture models: fixture k runs fx_r[k] cycles once launched, then stops with verdict fx_p[k].
  int unsigned  fx_r [N];
  bit           fx_p [N];
  int unsigned  fx_cnt [2][N];
  bit [N-1:0]   fx_stop [2];
  logic [N-1:0] fx_rearm = '0;
  logic [N-1:0] noise_run = '0, noise_pass = '0;
  logic [N-1:0] run_v [2];
  logic [N-1:0] rn0, rn1, ps0, ps1;
  logic [N-1:0] pvec;

  assign run_v[0] = bus0.o_run;
  assign run_v[1] = bus1.o_run;
  assign bus0.i_start = start;
  assign bus1.i_start = start;

  always_comb begin
    for (int k = 0; k < N; k++) pvec[k] = fx_p[k];
    rn0 = (bus0.o_run & ~fx_stop[0])         | (~bus0.o_run & noise_run);
    rn1 = (bus1.o_run & ~fx_stop[1])         | (~bus1.o_run & noise_run);
    ps0 = (bus0.o_run & fx_stop[0] & pvec)   | (~bus0.o_run & noise_pass);
    ps1 = (bus1.o_run & fx_stop[1] & pvec)   | (~bus1.o_run & noise_pass);
  end
  assign bus0.i_running = rn0;
  assign bus1.i_running = rn1;
  assign bus0.i_passed  = ps0;
  assign bus1.i_passed  = ps1;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      for (int k = 0; k < N; k++) begin
        if (fx_rearm[k]) begin
          fx_cnt[u][k]  <= 0;
          fx_stop[u][k] <= 1'b0;
        end else if (run_v[u][k] && !fx_stop[u][k]) begin
          fx_cnt[u][k] <= fx_cnt[u][k] + 1;
          if (fx_cnt[u][k] + 1 >= fx_r[k]) fx_stop[u][k] <= 1'b1;
        end
      end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  obs_t trace [2][TL];
  int   base = BIG, kill = BIG;
  bit   chk_en = 1'b0;
  int   n_cmp = 0, n_err = 0;

  task automatic put(input int u, input int o, input obs_t v);
    if (o >= 0 && o < TL) trace[u][o] = v;
  endtask

  // Timeline: fixture k occupies one launch cycle plus min(R,TIMEOUT) wait cycles, then one NEXT cycle.
  task automatic build(input int u, input logic [N-1:0] stale);
    int c = 0;
    int done_at = TL;
    logic [N-1:0] acc = '0;
    logic tflag = 1'b0;
    logic pass_all = 1'b0;
    bit fin = 1'b0;
    obs_t v;
    for (int k = 0; k < N && !fin; k++) begin
      int w;
      bit f, t;
      if (stale[k])          begin w = 0;        f = 1'b1;    t = 1'b0; end
      else if (fx_r[k] <= TO) begin w = fx_r[k]; f = !fx_p[k]; t = 1'b0; end
      else                   begin w = TO;       f = 1'b1;    t = 1'b1; end
      for (int o = c; o <= c + w; o++) begin
        v = '0; v.run = N'(1) << k; v.busy = 1'b1; v.fail = acc; v.to = tflag;
        put(u, o, v);
      end
      acc[k] = f;
      tflag  = tflag | t;
      v = '0; v.busy = 1'b1; v.fail = acc; v.to = tflag;
      put(u, c + w + 1, v);
      if (k == N - 1 || (u == 0 && f)) begin
        done_at  = c + w + 2;
        pass_all = (acc == '0) && (k == N - 1);
        fin      = 1'b1;
      end
      c = c + w + 2;
    end
    for (int o = done_at; o < TL; o++) begin
      v = '0; v.done = 1'b1; v.passed = pass_all; v.fail = acc; v.to = tflag;
      put(u, o, v);
    end
  endtask

  function automatic obs_t exp_at(input int u);
    int o;
    if (cyc >= base && cyc < kill) begin
      o = cyc - base;
      if (o >= TL) o = TL - 1;
      return trace[u][o];
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic compare_loop();
    obs_t a0, a1;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        a0 = {bus0.o_run, bus0.o_busy, bus0.o_done, bus0.o_passed, bus0.o_fail_vec, bus0.o_timeout};
        a1 = {bus1.o_run, bus1.o_busy, bus1.o_done, bus1.o_passed, bus1.o_fail_vec, bus1.o_timeout};
        chk($sformatf("dut0_cyc%0d", cyc), 32'(a0), 32'(exp_at(0)));
        chk($sformatf("dut1_cyc%0d", cyc), 32'(a1), 32'(exp_at(1)));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    noise_run  = N'($urandom);
    noise_pass = N'($urandom);
  endtask

  // Reset both runners, re-arm the selected fixtures, then start with i_start held high.
  task automatic launch(input logic [N-1:0] rearm, input logic [N-1:0] stale);
    kill = cyc + 1;
    rst_n = 1'b0;
    start = 1'b0;
    fx_rearm = rearm;
    tick();
    chk_en = 1'b1;
    fx_rearm = '0;
    tick();
    build(0, stale);
    build(1, stale);
    base = cyc + 1;
    kill = BIG;
    rst_n = 1'b1;
    start = 1'b1;
  endtask

  task automatic wait_done(output int off0, output int off1, output int run2);
    off0 = -1; off1 = -1; run2 = 0;
    for (int i = 0; i < 200 && (off0 < 0 || off1 < 0); i++) begin
      tick();
      if (bus0.o_run[2]) run2++;
      if (off0 < 0 && bus0.o_done) off0 = cyc - base;
      if (off1 < 0 && bus1.o_done) off1 = cyc - base;
    end
    if (off0 < 0 || off1 < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: got done0=%0d done1=%0d want both set within 200 cycles",
               bus0.o_done, bus1.o_done);
    end
  endtask

  task automatic set_fx(input int r0, r1, r2, r3, input bit p0, p1, p2, p3);
    fx_r[0] = r0; fx_r[1] = r1; fx_r[2] = r2; fx_r[3] = r3;
    fx_p[0] = p0; fx_p[1] = p1; fx_p[2] = p2; fx_p[3] = p3;
  endtask

  initial begin
    int d0, d1, r2;
    fork
      compare_loop();
    join_none
    for (int k = 0; k < N; k++) begin fx_r[k] = 1; fx_p[k] = 1'b1; end

    // All pass: done after 2*4 overhead + 24 running cycles.
    set_fx(3, 5, 1, 15, 1, 1, 1, 1);
    launch('1, '0);
    wait_done(d0, d1, r2);
    chk("s1_done_off0", d0, 32);
    chk("s1_done_off1", d1, 32);
    chk("s1_passed0", bus0.o_passed, 1);
    chk("s1_fail0", bus0.o_fail_vec, 0);

    // Fixture 1 fails.
    set_fx(4, 6, 3, 2, 1, 0, 1, 1);
    launch('1, '0);
    wait_done(d0, d1, r2);
    chk("s2_done_off0", d0, 14);
    chk("s2_fail0", bus0.o_fail_vec, 4'b0010);
    chk("s2_fail1", bus1.o_fail_vec, 4'b0010);
    chk("s2_passed0", bus0.o_passed, 0);
    chk("s2_passed1", bus1.o_passed, 0);
    chk("s2_fx2_unrun", fx_cnt[0][2], 0);
    chk("s2_fx3_unrun", fx_cnt[0][3], 0);

    // Fixture 2 hangs: watchdog after launch + 16 wait cycles.
    set_fx(2, 3, 1000, 2, 1, 1, 1, 1);
    launch('1, '0);
    wait_done(d0, d1, r2);
    chk("s3_run2_cycles", r2, 17);
    chk("s3_fail0", bus0.o_fail_vec, 4'b0100);
    chk("s3_timeout0", bus0.o_timeout, 1);
    chk("s3_fail1", bus1.o_fail_vec, 4'b0100);
    chk("s3_timeout1", bus1.o_timeout, 1);

    // Completion on the last watchdog cycle counts as a pass.
    set_fx(16, 1, 1, 1, 1, 1, 1, 1);
    launch('1, '0);
    wait_done(d0, d1, r2);
    chk("s4_timeout0", bus0.o_timeout, 0);
    chk("s4_passed0", bus0.o_passed, 1);

    // Reset mid-wait of fixture 1; fixture 0 stays stopped and is stale on the rerun.
    set_fx(3, 10, 2, 2, 1, 1, 1, 1);
    launch('1, '0);
    while (cyc < base + 7) tick();
    chk("s5_in_wait_f1", bus0.o_run, 4'b0010);
    launch(4'b1110, 4'b0001);
    chk("s5_reset_run0", bus0.o_run, 0);
    chk("s5_reset_busy0", bus0.o_busy, 0);
    wait_done(d0, d1, r2);
    chk("s5_fail0", bus0.o_fail_vec, 4'b0001);
    chk("s5_fail1", bus1.o_fail_vec, 4'b0001);
    chk("s5_passed1", bus1.o_passed, 0);

    // Randomised fixtures straddling the watchdog limit.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < N; k++) begin
        fx_r[k] = $urandom_range(20, 1);
        fx_p[k] = ($urandom_range(3, 0) != 0);
      end
      launch('1, '0);
      wait_done(d0, d1, r2);
    end

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
